// File: rtl/seq_det_pkg.sv
// Shared defaults and configuration helpers for the parametrised sequence detector.
package seq_det_pkg;

  localparam int unsigned DEF_PAT_W = 3;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 3'b101;
  localparam int unsigned DEF_CNT_W = 8;

  // A zero or oversized length selects the full pattern width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and overlap mode.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W       = DEF_PAT_W,
  parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(DEF_PATTERN),
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter int unsigned      LEN_W       = $clog2(PAT_W) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  output logic             match,
  output logic [CNT_W-1:0] match_count
);

  logic [PAT_W-1:0] pat_q, hist_q, hist_n, mask;
  logic [LEN_W-1:0] len_q, fill_q, fill_n, cfg_len_c;
  logic             ovl_q, hit;
  logic             unused_hist_msb;

  // Oldest history bit falls off the end of the shift and is never compared.
  assign unused_hist_msb = hist_q[PAT_W-1];

  always_comb begin
    hist_n    = {hist_q[PAT_W-2:0], in_bit};
    fill_n    = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    cfg_len_c = LEN_W'(clamp_len(32'(cfg_len), PAT_W));
    mask      = '0;
    for (int i = 0; i < PAT_W; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    hit = (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= RST_PATTERN;
      len_q  <= LEN_W'(PAT_W);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
      match  <= 1'b0;
    end else if (cfg_load) begin
      pat_q  <= cfg_pattern;
      len_q  <= cfg_len_c;
      ovl_q  <= cfg_overlap;
      hist_q <= '0;
      fill_q <= '0;
      match  <= 1'b0;
    end else if (in_valid) begin
      hist_q <= hist_n;
      // Non-overlapping mode forgets the matched bits so the next match needs len fresh ones.
      fill_q <= (hit && !ovl_q) ? '0 : fill_n;
      match  <= hit;
    end else begin
      match  <= 1'b0;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk(clk),
    .rst(rst),
    .clr(cfg_load),
    .inc(in_valid && !cfg_load && hit),
    .q  (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: three detector instances (default, 8-bit pattern, 2-bit counter).
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: default parameters
  logic rst0 = 0, ld0 = 0, v0 = 0, b0 = 0, o0 = 0, m0;
  logic [2:0] pat0 = '0, len0 = '0;
  logic [7:0] c0;
  // Instance 1: PAT_W = 8
  logic rst1 = 0, ld1 = 0, v1 = 0, b1 = 0, o1 = 0, m1;
  logic [7:0] pat1 = '0;
  logic [3:0] len1 = '0;
  logic [7:0] c1;
  // Instance 2: CNT_W = 2
  logic rst2 = 0, ld2 = 0, v2 = 0, b2 = 0, o2 = 0, m2;
  logic [2:0] pat2 = '0, len2 = '0;
  logic [1:0] c2;

  seq_detector_param u_dut0 (
    .clk(clk), .rst(rst0), .in_bit(b0), .in_valid(v0), .cfg_load(ld0),
    .cfg_pattern(pat0), .cfg_len(len0), .cfg_overlap(o0), .match(m0), .match_count(c0)
  );

  seq_detector_param #(
    .PAT_W(8), .RST_PATTERN(8'h00)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .in_bit(b1), .in_valid(v1), .cfg_load(ld1),
    .cfg_pattern(pat1), .cfg_len(len1), .cfg_overlap(o1), .match(m1), .match_count(c1)
  );

  seq_detector_param #(
    .CNT_W(2)
  ) u_dut2 (
    .clk(clk), .rst(rst2), .in_bit(b2), .in_valid(v2), .cfg_load(ld2),
    .cfg_pattern(pat2), .cfg_len(len2), .cfg_overlap(o2), .match(m2), .match_count(c2)
  );

  typedef struct {
    int id;
    bit m;
    int c;
    int step;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int step_no = 0;

  // One cycle of stimulus on instance id; expectation is queued after the consuming edge.
  task automatic drive(input int id, input bit r, input bit ld, input logic [7:0] p,
                       input int l, input bit o, input bit v, input bit b,
                       input bit em, input int ec);
    exp_t e;
    case (id)
      0: begin rst0 = r; ld0 = ld; pat0 = p[2:0]; len0 = 3'(l); o0 = o; v0 = v; b0 = b; end
      1: begin rst1 = r; ld1 = ld; pat1 = p;      len1 = 4'(l); o1 = o; v1 = v; b1 = b; end
      default: begin rst2 = r; ld2 = ld; pat2 = p[2:0]; len2 = 3'(l); o2 = o; v2 = v; b2 = b; end
    endcase
    @(posedge clk);
    #1;
    e.id = id; e.m = em; e.c = ec; e.step = step_no;
    exp_q.push_back(e);
    step_no++;
    case (id)
      0: begin rst0 = 0; ld0 = 0; v0 = 0; end
      1: begin rst1 = 0; ld1 = 0; v1 = 0; end
      default: begin rst2 = 0; ld2 = 0; v2 = 0; end
    endcase
  endtask

  task automatic do_rst(input int id);
    drive(id, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(input int id, input bit b, input bit em, input int ec);
    drive(id, 0, 0, 8'h00, 0, 0, 1, b, em, ec);
  endtask

  task automatic idle(input int id, input int ec);
    drive(id, 0, 0, 8'h00, 0, 0, 0, 0, 0, ec);
  endtask

  task automatic load(input int id, input logic [7:0] p, input int l, input bit o,
                      input bit v, input bit b);
    drive(id, 0, 1, p, l, o, v, b, 0, 0);
  endtask

  // Monitor: compare every queued expectation against the registered outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      bit am;
      int ac;
      e = exp_q.pop_front();
      case (e.id)
        0: begin am = m0; ac = 32'(c0); end
        1: begin am = m1; ac = 32'(c1); end
        default: begin am = m2; ac = 32'(c2); end
      endcase
      n_tests++;
      if (am !== e.m) begin
        n_fail++;
        $display("FAIL d%0d_s%0d_match: got %b, expected %b", e.id, e.step, am, e.m);
      end
      n_tests++;
      if (ac != e.c) begin
        n_fail++;
        $display("FAIL d%0d_s%0d_count: got %0d, expected %0d", e.id, e.step, ac, e.c);
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_rst(0);
    do_rst(1);
    do_rst(2);

    // Default 101 overlapping: 1,0,1,0,1 -> pulses after bits 3 and 5
    send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 1);
    send(0, 0, 0, 1); send(0, 1, 1, 2); idle(0, 2);

    // Non-overlapping 101: single pulse, load clears the count
    load(0, 8'b101, 3, 0, 0, 0);
    send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 1);
    send(0, 0, 0, 1); send(0, 1, 0, 1); idle(0, 1);

    // cfg_len = 0 acts as 3; the same-edge bit is discarded
    load(0, 8'b110, 0, 1, 1, 1);
    send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 0, 0, 0);
    send(0, 1, 0, 0); send(0, 1, 0, 0); send(0, 0, 1, 1); idle(0, 1);

    // cfg_len = 7 exceeds PAT_W and is clamped to 3
    load(0, 8'b011, 7, 1, 0, 0);
    send(0, 0, 0, 0); send(0, 1, 0, 0); send(0, 1, 1, 1); idle(0, 1);

    // Mid-stream reset discards history and restores pattern 101
    do_rst(0);
    send(0, 1, 0, 0); send(0, 0, 0, 0);
    do_rst(0);
    send(0, 1, 0, 0); send(0, 0, 0, 0); send(0, 1, 1, 1); idle(0, 1);

    // 8-bit pattern 1101_0011 with idle gaps: one pulse after the 9th bit
    load(1, 8'b1101_0011, 8, 1, 0, 0);
    send(1, 0, 0, 0); idle(1, 0); send(1, 1, 0, 0); idle(1, 0);
    send(1, 1, 0, 0); idle(1, 0); send(1, 0, 0, 0); idle(1, 0);
    send(1, 1, 0, 0); idle(1, 0); send(1, 0, 0, 0); idle(1, 0);
    send(1, 0, 0, 0); idle(1, 0); send(1, 1, 0, 0); idle(1, 0);
    send(1, 1, 1, 1); idle(1, 1);

    // 2-bit counter, pattern 11 overlapping: six 1s saturate at 3
    load(2, 8'b011, 2, 1, 0, 0);
    send(2, 1, 0, 0); send(2, 1, 1, 1); send(2, 1, 1, 2);
    send(2, 1, 1, 3); send(2, 1, 1, 3); send(2, 1, 1, 3); idle(2, 3);

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector: the successor to the team's fixed "101" Mealy detector. It takes one bit per qualified cycle and compares the most recent `len` bits against a runtime-loadable pattern of up to `PAT_W` bits. Overlapping and non-overlapping matching are both supported, and matches are counted with saturation. It sits on the serial input path and feeds control and status logic with a one-cycle `match` pulse and a running `match_count`.

## Interface
- `PAT_W`, 3: maximum pattern length in bits (legal range 2..16).
- `RST_PATTERN`, 3'b101: pattern loaded at reset (`PAT_W` bits).
- `CNT_W`, 8: width of `match_count`.
- `LEN_W`, $clog2(PAT_W)+1: width of `cfg_len` (derived; not overridden).

Ports:
- `clk`, in, 1: clock; all logic is on the rising edge.
- `rst`, in, 1: reset; synchronous, active-high.
- `in_bit`, in, 1: serial data bit.
- `in_valid`, in, 1: qualifies `in_bit`; the bit is consumed on any edge where this is high.
- `cfg_load`, in, 1: loads `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern`, in, `PAT_W`: pattern; bit [len-1] is the first bit received, bit [0] the last.
- `cfg_len`, in, `LEN_W`: active pattern length.
- `cfg_overlap`, in, 1: 1 = overlapping matches, 0 = non-overlapping.
- `match`, out, 1: registered pulse, high for one cycle per detected match.
- `match_count`, out, `CNT_W`: saturating count of matches.

## Operation
- Internal registers:
  - `pat`, `len`, `ovl`: active configuration.
  - `hist[PAT_W-1:0]`: shift history, newest bit in [0].
  - `fill`: 0..`PAT_W`, number of valid history bits.
  - `match`, `match_count`.
- Reset values:
  - `pat` = `RST_PATTERN`, `len` = `PAT_W`, `ovl` = 1.
  - `hist` = 0, `fill` = 0, `match` = 0, `match_count` = 0.
- Priority per edge: `rst` > `cfg_load` > `in_valid`.
- On `cfg_load`:
  - Latch the configuration.
  - If `cfg_len` is 0 or greater than `PAT_W`, use `PAT_W`.
  - Clear `hist`, `fill` and `match_count`; drive `match` = 0.
  - If `in_valid` is high on the same edge, that bit is discarded.
- On `in_valid` (no load):
  - `hist_n` = {`hist`[PAT_W-2:0], `in_bit`}.
  - `fill_n` = min(`fill`+1, `PAT_W`).
  - Hit when `fill_n` ≥ `len` and `hist_n`[len-1:0] == `pat`[len-1:0].
  - On a hit: `match` ← 1 and `match_count` ← `match_count`+1, saturating at all-ones (no wrap).
  - On a hit with `ovl` = 0: `fill` ← 0, so the next match needs `len` fresh bits.
  - On a hit with `ovl` = 1: `fill` ← `fill_n`.
  - No hit: `match` ← 0.
- `in_valid` low: `hist`, `fill` and `match_count` hold; `match` ← 0.
- Idle gaps in `in_valid` never break a partial match.
- There is no explicit state encoding. `fill` plus `hist` replace the s0/s1/s2 states of the fixed design. With the default configuration, overlapping behaviour is bit-exact with that design.

## Timing
- Latency: a match on the bit sampled at edge N gives `match` = 1 during cycle N→N+1. `match_count` updates at the same edge.
- `match` is never high for two consecutive cycles unless consecutive valid bits each complete a match. Example: pattern "11", overlap, stream 1,1,1 → pulses after the 2nd and 3rd bits.
- `rst` asserted mid-stream: next edge restores all reset values, including the default pattern, and discards the partial history.
- `cfg_load` takes effect at the edge. The first bit compared against the new pattern is the next valid bit.
- Throughput: one bit per cycle, no back-pressure.

## Structure
- Package `seq_det_pkg` holds:
  - Default constants: `DEF_PAT_W` = 3, `DEF_PATTERN` = 3'b101, `DEF_CNT_W` = 8.
  - A `clamp_len` function for `cfg_len` legalisation.
- Sub-module `sat_counter` (parameter `W`; ports `clk`, `rst`, `clr`, `inc`, `q`) implements `match_count`. Everything else stays in the top module.

## Test plan
- Reset defaults, overlap, stream 1,0,1,0,1 on consecutive valid cycles → `match` pulses after bits 3 and 5; `match_count` = 2.
- Same stream after loading pattern 101, len 3, overlap 0 → single pulse after bit 3; `match_count` = 1.
- `PAT_W` = 8, load 8'b1101_0011, len 8; send 0,1,1,0,1,0,0,1,1 with `in_valid` low between every bit → exactly one pulse, one cycle after the 9th valid bit.
- Load with `cfg_len` = 0 → behaves as len = `PAT_W`. Same-edge `cfg_load` + `in_valid` → the bit is ignored and the history is empty.
- `CNT_W` = 2, pattern "11", overlap, six 1s → `match_count` goes 1, 2, 3, 3, 3; `match` pulses 5 times.
- `rst` pulsed after bits 1,0 of 101, then 1 → no match; a following 0,1 → match (fresh history).
